rrobin_sched: RTL and testbench

- N-way round-robin scheduler that shares one resource among N requesters. It generalises the two-requester arbiter to parameterised N.
- Request inputs are latched. One-hot grants are issued with a rotating priority pointer and a bounded hold quota, so every persistent requester is served within a fixed bound.
- It sits between requester-side request lines and the shared resource's select/enable inputs.

---
 rtl/rrobin_pkg.sv | 34 +++
 rtl/rr_pick.sv | 42 ++++
 rtl/rrobin_sched.sv | 189 ++++++++++++++++++
 tb/tb_rrobin_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rrobin_pkg.sv
// -----------------------------------------------------------------------------
// rrobin_pkg
// Shared types and helpers for the N-way round-robin scheduler.
//   state_e        : scheduler FSM state {IDLE, BUSY}
//   HOLD_CNT_W     : width of the per-owner hold counter
//   rr_clog2()     : ceil(log2(value)), used to size index fields
//   starve_bound() : worst-case wait (n-1)*hold+1 before a requester is
//                    considered starved (used by RRSCHED_STARVE_MON_EN)
// -----------------------------------------------------------------------------
package rrobin_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int HOLD_CNT_W = 8;

    function automatic int rr_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int starve_bound(input int n, input int hold);
        return (n - 1) * hold + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational rotating-priority finder: returns the first set bit of
// v searching s, s+1, ..., N-1, 0, ..., s-1.
// Ports:
//   v     : input  [N-1:0]  candidate vector
//   s     : input  [IW-1:0] start index of the search (expected < N)
//   found : output          at least one bit of v is set
//   idx   : output [IW-1:0] index of the first set bit (0 when none)
// -----------------------------------------------------------------------------
module rr_pick
    import rrobin_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = rr_clog2(N)
) (
    input  logic [N-1:0]  v,
    input  logic [IW-1:0] s,
    output logic          found,
    output logic [IW-1:0] idx
);

    int cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            // wrap the search position back into 0..N-1
            cand = int'(s) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && v[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/rrobin_sched.sv
// -----------------------------------------------------------------------------
// rrobin_sched
// N-way round-robin scheduler sharing one resource among N requesters.
// Requests are latched into req_q; decisions use req_q only, so a request
// rising at edge k shows up as a grant after edge k+1. A grant owner may keep
// the resource for at most HOLD consecutive cycles while others wait; a sole
// requester keeps it indefinitely.
//
// Ports:
//   clock       : input           single clock, posedge
//   reset       : input           asynchronous active-high reset
//   req         : input  [N-1:0]  raw request lines
//   grant       : output [N-1:0]  registered one-hot grant (0 when idle)
//   grant_valid : output          registered OR of grant
//   grant_id    : output [IW-1:0] index of current owner (0 when idle)
//   starve_err  : output [N-1:0]  sticky starvation flags
//
// Configuration:
//   RRSCHED_STARVE_MON_EN : when defined, per-requester wait counters drive
//                           starve_err; otherwise starve_err is constant 0.
// -----------------------------------------------------------------------------
module rrobin_sched
    import rrobin_pkg::*;
#(
    parameter int N    = 4,
    parameter int HOLD = 4,
    localparam int IW  = rr_clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_id,
    output logic [N-1:0]  starve_err
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_MAX = HOLD_CNT_W'(HOLD - 1);
    localparam logic [IW-1:0]         LAST_IDX = IW'(N - 1);
    localparam logic [N-1:0]          ONE_N    = N'(1);

    state_e                state_q, state_d;
    logic [N-1:0]          req_q;
    logic [N-1:0]          grant_q, grant_d;
    logic                  grant_valid_q, grant_valid_d;
    logic [IW-1:0]         grant_id_q, grant_id_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [N-1:0]  others;
    logic          owner_req;
    logic [IW-1:0] owner_next;
    logic          all_found, rot_found;
    logic [IW-1:0] all_idx, rot_idx;
    logic          take_new;
    logic [IW-1:0] new_idx;

    // grant_q is one-hot of the owner while BUSY, so it doubles as the owner mask
    assign others     = req_q & ~grant_q;
    assign owner_req  = |(req_q & grant_q);
    assign owner_next = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + 1'b1;

    // start-of-service pick from IDLE on the full latched request vector
    rr_pick #(.N(N)) u_pick_all (
        .v     (req_q),
        .s     (ptr_q),
        .found (all_found),
        .idx   (all_idx)
    );

    // rotation pick on the other requesters, starting just past the owner
    rr_pick #(.N(N)) u_pick_rot (
        .v     (others),
        .s     (owner_next),
        .found (rot_found),
        .idx   (rot_idx)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        take_new   = 1'b0;
        new_idx    = '0;

        case (state_q)
            IDLE: begin
                if (all_found) begin
                    take_new = 1'b1;
                    new_idx  = all_idx;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    if (rot_found) begin
                        // owner released: hand over with no idle bubble
                        take_new = 1'b1;
                        new_idx  = rot_idx;
                    end else begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        grant_id_d = '0;
                    end
                end else if (rot_found && (hold_cnt_q == HOLD_MAX)) begin
                    take_new = 1'b1;
                    new_idx  = rot_idx;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                grant_id_d = '0;
            end
        endcase

        if (take_new) begin
            state_d    = BUSY;
            grant_d    = ONE_N << new_idx;
            grant_id_d = new_idx;
            ptr_d      = (new_idx == LAST_IDX) ? '0 : new_idx + 1'b1;
            hold_cnt_d = '0;
        end

        grant_valid_d = |grant_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            req_q         <= req;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

`ifdef RRSCHED_STARVE_MON_EN
    localparam int STARVE_LIMIT = starve_bound(N, HOLD);

    logic [HOLD_CNT_W-1:0] wait_cnt_q [N];
    logic [N-1:0]          starve_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                wait_cnt_q[i] <= '0;
            end
            starve_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_q[i] && !grant_q[i]) begin
                    if (wait_cnt_q[i] != {HOLD_CNT_W{1'b1}}) begin
                        wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
                    end
                end else begin
                    wait_cnt_q[i] <= '0;
                end
                // sticky until reset
                if (32'(wait_cnt_q[i]) > 32'(STARVE_LIMIT)) begin
                    starve_q[i] <= 1'b1;
                end
            end
        end
    end

    assign starve_err = starve_q;
`else
    assign starve_err = '0;
`endif

endmodule

// File: tb/tb_rrobin_sched.sv
// -----------------------------------------------------------------------------
// tb_rrobin_sched
// Directed bench for rrobin_sched (N=4, HOLD=4). Expected per-cycle
// {grant_valid, grant_id, grant} words are queued when stimulus is driven and
// popped against the outputs one cycle at a time.
// -----------------------------------------------------------------------------
module tb_rrobin_sched;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int IW   = 2;
    localparam int W    = 1 + IW + N;

    logic          clock;
    logic          reset;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic [N-1:0]  starve_err;

    logic [W-1:0] exp_q[$];
    int total;
    int bad;

    rrobin_sched #(.N(N), .HOLD(HOLD)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .starve_err  (starve_err)
    );

    // clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // watchdog
    initial begin
        #60000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_own(input int o, input int n);
        logic [N-1:0] oh;
        oh = N'(1) << o;
        repeat (n) exp_q.push_back({1'b1, IW'(o), oh});
    endtask

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back('0);
    endtask

    task automatic drain(input string tag);
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            chk(tag, 32'({grant_valid, grant_id, grant}), 32'(e));
            chk({tag, "_starve"}, 32'(starve_err), 32'(0));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req   = '0;

        // reset state
        #12;
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_valid", 32'(grant_valid), 32'(0));
        chk("rst_id", 32'(grant_id), 32'(0));
        chk("rst_starve", 32'(starve_err), 32'(0));
        reset = 1'b0;

        // single requester, held well past the hold quota
        req = 4'b0010;
        push_idle(1);
        push_own(1, HOLD + 20);
        drain("single");
        req = 4'b0000;
        push_own(1, 1);
        push_idle(2);
        drain("single_rel");

        // two requesters alternate every HOLD cycles (ptr is 2 here, so 0 first)
        req = 4'b0011;
        push_idle(1);
        push_own(0, HOLD);
        push_own(1, HOLD);
        push_own(0, HOLD);
        push_own(1, HOLD);
        drain("contend");
        req = 4'b0000;
        push_own(0, 1);
        push_idle(1);
        drain("contend_rel");

        // all four after reset: 0,1,2,3 then wrap to 0
        #3;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        req = 4'b1111;
        push_idle(1);
        push_own(0, HOLD);
        push_own(1, HOLD);
        push_own(2, HOLD);
        push_own(3, HOLD);
        push_own(0, HOLD);
        drain("all4");
        req = 4'b0000;
        push_own(1, 1);
        push_idle(1);
        drain("all4_rel");

        // owner 2 drops early while 0 and 3 wait: direct handover to 3
        req = 4'b0100;
        push_idle(1);
        push_own(2, 1);
        drain("drop_a");
        req = 4'b1001;
        push_own(2, 1);
        push_own(3, HOLD);
        push_own(0, HOLD);
        push_own(3, HOLD);
        drain("drop_b");
        req = 4'b0000;
        push_own(0, 1);
        push_idle(1);
        drain("drop_rel");

        // async reset mid-BUSY clears outputs without waiting for an edge
        req = 4'b0100;
        push_idle(1);
        push_own(2, 3);
        drain("busy");
        #3;
        reset = 1'b1;
        #1;
        chk("areset_grant", 32'(grant), 32'(0));
        chk("areset_valid", 32'(grant_valid), 32'(0));
        chk("areset_id", 32'(grant_id), 32'(0));
        #10;
        reset = 1'b0;
        push_idle(1);
        push_own(2, 2);
        drain("post_reset");
        req = 4'b0000;
        push_own(2, 1);
        push_idle(1);
        drain("post_reset_rel");

`ifdef RRSCHED_STARVE_MON_EN
        // stall grants so both requesters wait beyond (N-1)*HOLD+1
        #3;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        req = 4'b0011;
        step();
        step();
        force dut.grant_q = '0;
        repeat (20) step();
        release dut.grant_q;
        chk("starve_set", 32'(starve_err), 32'(4'b0011));
        req = 4'b0000;
        repeat (3) step();
        chk("starve_sticky", 32'(starve_err), 32'(4'b0011));
        #3;
        reset = 1'b1;
        #1;
        chk("starve_clr", 32'(starve_err), 32'(0));
        reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
